usart_rx_v1: RTL and testbench

- UART receiver, the receive-side counterpart of the team's UART transmitter; same frame format and the same 16x bit-clock enable (i_bps_en).
- Frame: 1 start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
- Sits between the FPGA RX pin and the host-command parser.
- Delivers each byte with a one-cycle valid pulse plus parity and framing status.

---
 rtl/usart_rx_v1.sv | 142 ++++++++++++++
 tb/tb_usart_rx_v1.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usart_rx_v1.sv
// UART receiver: 16x oversampled, 3-sample majority per bit, 8N1 or 8-bit + parity frames.
// Delivers each byte with a one-cycle o_valid pulse and parity/framing status.
module usart_rx_v1 #(
    parameter int SYS_FRE   = 50,
    parameter int CHACK_WAY = 0
) (
    input  logic       i_sys_clk,
    input  logic       i_reset_n,
    input  logic       i_bps_en,
    input  logic       i_usart_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_busy
);

    // SYS_FRE only documents the clock the baud generator was sized for.
    if (SYS_FRE <= 0) begin : g_sys_fre_check
        $error("usart_rx_v1: SYS_FRE must be positive");
    end

    localparam logic PAR_EN  = (CHACK_WAY != 0);
    localparam logic PAR_ODD = (CHACK_WAY == 1) || (CHACK_WAY == 3);

    typedef enum logic [4:0] {
        IDLE       = 5'b00001,
        START_BIT  = 5'b00010,
        RECV_DATA  = 5'b00100,
        PARITY_BIT = 5'b01000,
        STOP_BIT   = 5'b10000
    } state_t;

    state_t      state;
    logic        rx_meta;
    logic        rx_s;
    logic [3:0]  cnt;
    logic [2:0]  idx;
    logic [7:0]  shift_reg;
    logic        s7;
    logic        s8;
    logic        armed;
    logic        par_err;
    logic        maj;
    logic        exp_par;

    // NOTE: synchronizer flops reset to 1 so a reset looks like an idle line, not a start edge.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_usart_rx;
            rx_s    <= rx_meta;
        end
    end

    // Samples 7 and 8 are stored; sample 9 is the live rx_s on the deciding tick.
    assign maj     = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
    assign exp_par = PAR_ODD ? ~^shift_reg : ^shift_reg;

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            idx          <= 3'd0;
            shift_reg    <= 8'd0;
            s7           <= 1'b1;
            s8           <= 1'b1;
            armed        <= 1'b0;
            par_err      <= 1'b0;
            o_data       <= 8'd0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            // NOTE: default-low every cycle makes o_valid a single-cycle pulse without extra state.
            o_valid <= 1'b0;
            if (i_bps_en) begin
                if (state != IDLE) begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd7) s7 <= rx_s;
                    if (cnt == 4'd8) s8 <= rx_s;
                end
                case (state)
                    IDLE: begin
                        if (rx_s) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            // The detecting tick is tick 0 of the start bit.
                            state   <= START_BIT;
                            cnt     <= 4'd1;
                            o_busy  <= 1'b1;
                            par_err <= 1'b0;
                        end
                    end
                    START_BIT: begin
                        if (cnt == 4'd9 && maj) begin
                            state  <= IDLE;
                            cnt    <= 4'd0;
                            o_busy <= 1'b0;
                        end else if (cnt == 4'd15) begin
                            state <= RECV_DATA;
                            idx   <= 3'd0;
                        end
                    end
                    RECV_DATA: begin
                        if (cnt == 4'd9) shift_reg[idx] <= maj;
                        if (cnt == 4'd15) begin
                            idx <= idx + 3'd1;
                            if (idx == 3'd7) state <= PAR_EN ? PARITY_BIT : STOP_BIT;
                        end
                    end
                    PARITY_BIT: begin
                        if (cnt == 4'd9) par_err <= (maj != exp_par);
                        if (cnt == 4'd15) state <= STOP_BIT;
                    end
                    STOP_BIT: begin
                        // Leave at mid-stop so a back-to-back start edge is caught.
                        if (cnt == 4'd9) begin
                            o_data       <= shift_reg;
                            o_parity_err <= par_err;
                            o_frame_err  <= ~maj;
                            o_valid      <= 1'b1;
                            o_busy       <= 1'b0;
                            state        <= IDLE;
                            cnt          <= 4'd0;
                            armed        <= maj;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        cnt    <= 4'd0;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usart_rx_v1.sv
// Bench for usart_rx_v1: three instances (no/odd/even parity) driven by a tick-level serial
// model; a queue-based scoreboard checks every o_valid pulse against frames sent.
module tb_usart_rx_v1;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       bps_en;
    logic       rx_w     [3];
    logic [7:0] data_w   [3];
    logic       valid_w  [3];
    logic       perr_w   [3];
    logic       ferr_w   [3];
    logic       busy_w   [3];
    logic       prev_valid [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_cmp = 0;
    int n_err = 0;
    int div   = 0;

    usart_rx_v1 #(.SYS_FRE(50), .CHACK_WAY(0)) u_none (
        .i_sys_clk(clk), .i_reset_n(rst_n), .i_bps_en(bps_en), .i_usart_rx(rx_w[0]),
        .o_data(data_w[0]), .o_valid(valid_w[0]), .o_parity_err(perr_w[0]),
        .o_frame_err(ferr_w[0]), .o_busy(busy_w[0])
    );
    usart_rx_v1 #(.SYS_FRE(50), .CHACK_WAY(1)) u_odd (
        .i_sys_clk(clk), .i_reset_n(rst_n), .i_bps_en(bps_en), .i_usart_rx(rx_w[1]),
        .o_data(data_w[1]), .o_valid(valid_w[1]), .o_parity_err(perr_w[1]),
        .o_frame_err(ferr_w[1]), .o_busy(busy_w[1])
    );
    usart_rx_v1 #(.SYS_FRE(50), .CHACK_WAY(2)) u_even (
        .i_sys_clk(clk), .i_reset_n(rst_n), .i_bps_en(bps_en), .i_usart_rx(rx_w[2]),
        .o_data(data_w[2]), .o_valid(valid_w[2]), .o_parity_err(perr_w[2]),
        .o_frame_err(ferr_w[2]), .o_busy(busy_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One tick every 4th clock, updated on the falling edge so it is stable at posedge.
    initial bps_en = 1'b0;
    always @(negedge clk) begin
        div    = (div + 1) % 4;
        bps_en = (div == 0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic score(input int i);
        exp_t e;
        int   n;
        case (i)
            0:       n = q0.size();
            1:       n = q1.size();
            default: n = q2.size();
        endcase
        check($sformatf("spurious_valid_u%0d", i), (n == 0), 0);
        if (n > 0) begin
            case (i)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            check($sformatf("data_u%0d", i), data_w[i], e.data);
            check($sformatf("parity_err_u%0d", i), perr_w[i], e.perr);
            check($sformatf("frame_err_u%0d", i), ferr_w[i], e.ferr);
        end
    endtask

    initial for (int i = 0; i < 3; i++) prev_valid[i] = 1'b0;
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (valid_w[i]) begin
                check($sformatf("valid_width_u%0d", i), prev_valid[i], 0);
                score(i);
            end
            prev_valid[i] = valid_w[i];
        end
    end

    // Returns 1ns after the n-th tick edge, so line changes never race the DUT flops.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!bps_en);
            #1;
        end
    endtask

    // One data bit of 16 ticks, optionally with a single-tick inversion somewhere in it.
    task automatic drive_bit(input int i, input logic b, input bit noise);
        int pos;
        rx_w[i] = b;
        if (noise) begin
            pos = $urandom_range(0, 15);
            wait_ticks(pos);
            rx_w[i] = ~b;
            wait_ticks(1);
            rx_w[i] = b;
            wait_ticks(15 - pos);
        end else begin
            wait_ticks(16);
        end
    endtask

    // Sends one frame on instance i (parity mode = i); the line is left at stop_v.
    task automatic send_frame(input int i, input logic [7:0] d, input bit par_flip,
                              input bit stop_v, input bit noise);
        exp_t e;
        logic par_bit;
        // Odd parity: total ones including the parity bit is odd; even: total is even.
        if (i == 1) par_bit = ($countones(d) % 2 == 0);
        else        par_bit = ($countones(d) % 2 == 1);
        par_bit = par_bit ^ par_flip;
        e.data = d;
        e.perr = (i != 0) && par_flip;
        e.ferr = !stop_v;
        push_exp(i, e);

        rx_w[i] = 1'b0;
        wait_ticks(8);
        check($sformatf("busy_in_start_u%0d", i), busy_w[i], 1);
        wait_ticks(8);
        for (int b = 0; b < 8; b++) drive_bit(i, d[b], noise);
        if (i != 0) drive_bit(i, par_bit, 1'b0);
        rx_w[i] = stop_v;
        wait_ticks(12);
        check($sformatf("busy_after_stop_u%0d", i), busy_w[i], 0);
        wait_ticks(4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mid_byte;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) rx_w[i] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_data_u%0d", i), data_w[i], 0);
            check($sformatf("rst_valid_u%0d", i), valid_w[i], 0);
            check($sformatf("rst_perr_u%0d", i), perr_w[i], 0);
            check($sformatf("rst_ferr_u%0d", i), ferr_w[i], 0);
            check($sformatf("rst_busy_u%0d", i), busy_w[i], 0);
        end
        rst_n = 1'b1;
        wait_ticks(20);

        // Back-to-back loopback, no parity.
        send_frame(0, 8'h55, 1'b0, 1'b1, 1'b0);
        send_frame(0, 8'hA3, 1'b0, 1'b1, 1'b0);
        send_frame(0, 8'h00, 1'b0, 1'b1, 1'b0);
        send_frame(0, 8'hFF, 1'b0, 1'b1, 1'b0);
        wait_ticks(8);

        // Parity: even with good/bad bit, odd with bad/good bit.
        send_frame(2, 8'h3C, 1'b0, 1'b1, 1'b0);
        send_frame(2, 8'h3C, 1'b1, 1'b1, 1'b0);
        send_frame(1, 8'h01, 1'b1, 1'b1, 1'b0);
        send_frame(1, 8'h01, 1'b0, 1'b1, 1'b0);
        wait_ticks(8);

        // Glitch: 4-tick low pulse must be rejected as a false start.
        rx_w[0] = 1'b0;
        wait_ticks(3);
        check("glitch_busy_high", busy_w[0], 1);
        wait_ticks(1);
        rx_w[0] = 1'b1;
        wait_ticks(8);
        check("glitch_busy_low", busy_w[0], 0);
        wait_ticks(4);
        send_frame(0, 8'h81, 1'b0, 1'b1, 1'b0);
        wait_ticks(4);

        // Frame error then a 40-bit break: exactly one byte expected.
        send_frame(0, 8'h7E, 1'b0, 1'b0, 1'b0);
        wait_ticks(320);
        check("break_busy", busy_w[0], 0);
        wait_ticks(320);
        rx_w[0] = 1'b1;
        wait_ticks(32);
        send_frame(0, 8'h12, 1'b0, 1'b1, 1'b0);
        wait_ticks(8);

        // Reset during data bit 4 of 0xC5.
        mid_byte = 8'hC5;
        rx_w[0] = 1'b0;
        wait_ticks(16);
        for (int b = 0; b < 4; b++) drive_bit(0, mid_byte[b], 1'b0);
        rx_w[0] = mid_byte[4];
        wait_ticks(8);
        check("midframe_busy", busy_w[0], 1);
        rst_n = 1'b0;
        #1;
        check("midrst_data", data_w[0], 0);
        check("midrst_valid", valid_w[0], 0);
        check("midrst_perr", perr_w[0], 0);
        check("midrst_ferr", ferr_w[0], 0);
        check("midrst_busy", busy_w[0], 0);
        rx_w[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ticks(20);
        send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b0);
        wait_ticks(4);

        // Single-tick noise inside every data bit.
        send_frame(0, 8'h96, 1'b0, 1'b1, 1'b1);
        wait_ticks(4);

        // Randomized frames across all three parity modes.
        for (int k = 0; k < 24; k++) begin
            int         inst;
            int         gap;
            logic [7:0] d;
            bit         flip;
            bit         stop_v;
            bit         noise;
            inst   = $urandom_range(0, 2);
            d      = 8'($urandom);
            flip   = 1'($urandom_range(0, 1));
            stop_v = ($urandom_range(0, 5) != 0);
            noise  = 1'($urandom_range(0, 1));
            send_frame(inst, d, flip, stop_v, noise);
            gap = stop_v ? $urandom_range(0, 8) : $urandom_range(2, 8);
            rx_w[inst] = 1'b1;
            wait_ticks(gap);
        end

        wait_ticks(40);
        check("drain_u0", q0.size(), 0);
        check("drain_u1", q1.size(), 0);
        check("drain_u2", q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
